// File: rtl/operand_pkg.sv
// Shared types for the operand packer: FSM state encoding and operand containers.
package operand_pkg;

    localparam int DEFAULT_WIDTH = 32;

    // Which word of the operand set the packer expects next.
    typedef enum logic [1:0] {
        S_A = 2'd0,
        S_B = 2'd1,
        S_C = 2'd2,
        S_D = 2'd3
    } state_e;

    typedef logic signed [DEFAULT_WIDTH-1:0] operand_t;

    typedef struct packed {
        operand_t a;
        operand_t b;
        operand_t c;
        operand_t d;
    } operand_set_t;

endpackage

// File: rtl/operand_packer.sv
// Serial-to-parallel operand packer: collects four signed words (a, b, c, d)
// from a valid/ready stream and presents them as one set to the arithmetic core.
//
// state | meaning
// ------+-------------------------------------------------------------
// S_A   | waiting for a word flagged in_first (operand a)
// S_B   | a staged, waiting for operand b
// S_C   | a, b staged, waiting for operand c
// S_D   | a, b, c staged, next word completes the set (may stall on output)
module operand_packer
    import operand_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_data,
    input  logic                    in_first,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] a,
    output logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] c,
    output logic signed [WIDTH-1:0] d,
    output logic                    resync,
    output logic [CNT_W-1:0]        set_count
);

    state_e                  state;
    logic signed [WIDTH-1:0] stage_a;
    logic signed [WIDTH-1:0] stage_b;
    logic signed [WIDTH-1:0] stage_c;
    logic                    accept;
    logic                    handshake;

    // Only the completing word has to wait for the core; a, b and c keep
    // filling the staging registers while the previous set is still held.
    assign in_ready  = rst_n && !(state == S_D && out_valid && !out_ready);
    assign accept    = in_valid && in_ready;
    assign handshake = out_valid && out_ready;

    // Packing FSM, staging registers, output register and set counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_A;
            stage_a   <= '0;
            stage_b   <= '0;
            stage_c   <= '0;
            a         <= '0;
            b         <= '0;
            c         <= '0;
            d         <= '0;
            out_valid <= 1'b0;
            resync    <= 1'b0;
            set_count <= '0;
        end else begin
            resync <= 1'b0;

            // A completing word below may re-assert out_valid in the same
            // cycle, giving back-to-back sets with no bubble.
            if (handshake) begin
                out_valid <= 1'b0;
                set_count <= set_count + CNT_W'(1);
            end

            if (accept) begin
                if (in_first) begin
                    // Frame start always wins; anything partial is thrown away.
                    stage_a <= in_data;
                    state   <= S_B;
                    if (state != S_A) begin
                        resync <= 1'b1;
                    end
                end else begin
                    case (state)
                        S_A: begin
                            resync <= 1'b1;
                        end
                        S_B: begin
                            stage_b <= in_data;
                            state   <= S_C;
                        end
                        S_C: begin
                            stage_c <= in_data;
                            state   <= S_D;
                        end
                        S_D: begin
                            a         <= stage_a;
                            b         <= stage_b;
                            c         <= stage_c;
                            d         <= in_data;
                            out_valid <= 1'b1;
                            state     <= S_A;
                        end
                        default: begin
                            state <= S_A;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: doc/operand_packer.md
Name: operand_packer

Overview:
- Upstream stage for the signed arithmetic core (a, b, c, d -> q).
- Accepts a serial stream of signed WIDTH-bit words over a valid/ready handshake and assembles them into one operand set {a, b, c, d}.
- Presents the set in parallel, with valid/ready, to the core's operand inputs.
- Keeps collecting the next set while the previous one is held, and re-synchronises on a frame-start flag.

Parameters:
- WIDTH, 32, operand width in bits, two's complement.
- CNT_W, 16, width of the emitted-set counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data and in_first are valid.
- in_ready  output  1  packer accepts a word this cycle.
- in_data  input  WIDTH  signed operand word.
- in_first  input  1  marks the word as operand a (start of set).
- out_valid  output  1  a/b/c/d hold a complete set.
- out_ready  input  1  core consumes the set this cycle.
- a  output  WIDTH  signed operand a.
- b  output  WIDTH  signed operand b.
- c  output  WIDTH  signed operand c.
- d  output  WIDTH  signed operand d.
- resync  output  1  one-cycle pulse: partial set discarded, or stray word dropped.
- set_count  output  CNT_W  number of sets handed to the core; wraps modulo 2^CNT_W.

Behaviour:
- Reset (asynchronous assert, synchronous-to-clk deassert by the system):
  - state = S_A; out_valid = 0; a = b = c = d = 0; staging regs = 0; resync = 0; set_count = 0.
  - in_ready = 0 while rst_n is low.
- Word accept: in_valid && in_ready at a rising edge.
- FSM states S_A, S_B, S_C, S_D (next word expected):
  - S_A:
    - accepted word with in_first = 1 -> store stage_a, go to S_B.
    - accepted word with in_first = 0 -> drop it, pulse resync, stay in S_A.
  - S_B: store stage_b, go to S_C.
  - S_C: store stage_c, go to S_D.
  - S_D: load a <= stage_a, b <= stage_b, c <= stage_c, d <= in_data; set out_valid = 1; go to S_A.
  - S_B, S_C or S_D with in_first = 1 -> discard the partial set, store the word as stage_a, go to S_B, pulse resync. No output is produced for the discarded set.
- in_ready = rst_n && !(state == S_D && out_valid && !out_ready).
  - This is a combinational path from out_ready to in_ready, and it is intended.
  - In S_A, S_B and S_C, in_ready = 1 even while the output is held, so staging fills while the core stalls.
- Output handshake:
  - a, b, c, d are stable while out_valid && !out_ready.
  - out_valid && out_ready -> out_valid = 0 next cycle, unless a D word is accepted in the same cycle; then out_valid stays 1 with the new set (back-to-back, no bubble).
- Latency:
  - D word accepted at edge k -> out_valid = 1 and new operands visible from edge k onward (one register stage).
  - Throughput: one set per 4 accepted words at sustained rate.
- set_count increments on each cycle with out_valid && out_ready. Wraps 0xFFFF -> 0x0000 at CNT_W = 16.
- No arithmetic: words pass bit-exact. Sign is preserved, e.g. -99999 = 0xFFFE7961 at WIDTH = 32.
- Reset mid-set or while out_valid = 1: all state is lost, and no partial or held set is emitted after reset release.
- resync is registered: high for exactly the one cycle after the offending accept. Back-to-back offences give consecutive pulses.

Decomposition:
- Package operand_pkg:
  - typedef state_e {S_A, S_B, S_C, S_D}.
  - typedef operand_t = logic signed [WIDTH-1:0].
  - struct operand_set_t {a, b, c, d}.
  - localparam default WIDTH = 32.
- No sub-module. The FSM, staging regs and output register fit in one module (~150-200 lines).

Test Plan:
- Reset: hold rst_n = 0 for 10 time units -> in_ready = 0, out_valid = 0, a..d = 0, set_count = 0. After release, in_ready = 1.
- Basic set: words 5(first), -7, 100, -99999 with out_ready = 1 -> one cycle after the 4th accept, a = 5, b = -7, c = 100, d = -99999, out_valid = 1; set_count = 1 after the handshake.
- Backpressure: out_ready = 0, send two full sets -> the first set is held stable; in_ready drops only in S_D of the second set. Raise out_ready -> both sets are emitted in order, with no bubble between them.
- Resync: send 1(first), 2, 3(first), 4, 5, 6 -> resync pulses once; output is a = 3, b = 4, c = 5, d = 6; no set containing 1 or 2 is emitted.
- Stray word: in S_A send 9 with in_first = 0 -> dropped, resync pulse, state stays S_A, set_count unchanged.
- Mid-operation reset: assert rst_n = 0 after words a and b -> after release, send a full set 10, 20, 30, 40 -> output is exactly 10, 20, 30, 40, and set_count = 1.
